// File: rtl/cam_manager.sv
// cam_manager: request-side controller for a block-RAM CAM.
// Serialises insert/delete-by-key requests, uses the CAM compare port for
// duplicate detection and key lookup, allocates the lowest free entry from a
// valid bitmap, and issues single-cycle writes on the CAM write port.
module cam_manager #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_key,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_MISS  = 2'b01;  // FULL on insert, NOT_FOUND on delete
    localparam logic [1:0] ST_DUP   = 2'b10;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_WRITE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic                    r_op;
    logic [DATA_WIDTH-1:0]   r_key;
    logic [DEPTH-1:0]        r_bitmap;
    logic [ADDR_WIDTH:0]     r_used;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [1:0]              r_rsp_status;
    logic [ADDR_WIDTH-1:0]   r_rsp_addr;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_wr_del;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_cmp_data;
    logic                    r_wait_first;

    logic [ADDR_WIDTH-1:0]   w_free_idx;
    logic                    w_full;

    // Lowest clear bitmap index; descending scan so the smallest index wins.
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_bitmap[i]) begin
                w_free_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign w_full = (r_used == FULL_COUNT);

    // Control FSM with registered outputs; bitmap and occupancy change only on the write pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_op         <= 1'b0;
            r_key        <= '0;
            r_bitmap     <= '0;
            r_used       <= '0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= 2'b00;
            r_rsp_addr   <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_del     <= 1'b0;
            r_wr_en      <= 1'b0;
            r_cmp_data   <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    // CAM clears its RAMs after reset and reports busy meanwhile.
                    if (!cam_write_busy) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_key       <= req_key;
                        r_cmp_data  <= req_key;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // Settle cycle for the CAM compare/read path.
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!r_op) begin
                        if (cam_match) begin
                            r_rsp_status <= ST_DUP;
                            r_rsp_addr   <= cam_match_addr;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (w_full) begin
                            r_rsp_status <= ST_MISS;
                            r_rsp_addr   <= '0;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_wr_addr <= w_free_idx;
                            r_wr_data <= r_key;
                            r_wr_del  <= 1'b0;
                            r_state   <= S_WRITE;
                        end
                    end else begin
                        if (cam_match) begin
                            r_wr_addr <= cam_match_addr;
                            r_wr_data <= r_key;
                            r_wr_del  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_rsp_status <= ST_MISS;
                            r_rsp_addr   <= '0;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    if (!cam_write_busy) begin
                        r_wr_en               <= 1'b1;
                        r_bitmap[r_wr_addr]   <= ~r_wr_del;
                        r_used                <= r_wr_del ? (r_used - 1'b1) : (r_used + 1'b1);
                        r_wait_first          <= 1'b1;
                        r_state               <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The CAM raises busy only after it has seen the enable, so skip one cycle.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (!cam_write_busy) begin
                        r_rsp_status <= ST_OK;
                        r_rsp_addr   <= r_wr_addr;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_status       = r_rsp_status;
    assign rsp_addr         = r_rsp_addr;
    assign used_count       = r_used;
    assign cam_write_addr   = r_wr_addr;
    assign cam_write_data   = r_wr_data;
    assign cam_write_delete = r_wr_del;
    assign cam_write_enable = r_wr_en;
    assign cam_compare_data = r_cmp_data;

endmodule
